unidade_controle: RTL and testbench
===================================

UNIDADE_CONTROLE -- requirements
Module: unidade_controle

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 5000, sets the number of clock cycles allowed in ESPERA before a timeout; used only with JOGO_TIMEOUT_EN.
REQ-002 Port clock, input, 1, is the single clock; all state changes SHALL occur on its rising edge.
REQ-003 Port reset, input, 1, SHALL be asynchronous and active-low: reset=0 forces reset state immediately.
REQ-004 Port iniciar, input, 1, is the start request, sampled synchronously.
REQ-005 Port jogada_feita, input, 1, is a one-cycle pulse from the datapath edge detector.
REQ-006 Port igual, input, 1, is the datapath comparator result.
REQ-007 Port fimC, input, 1, is the datapath address counter terminal count.
REQ-008 Ports zeraC, contaC, zeraR, registraR are 1-bit outputs; each drives the datapath signal of the same name.
REQ-009 Ports acertou, errou, pronto are 1-bit status outputs.
REQ-010 Port timeout, output, 1, flags a timeout end; it is tied to 0 without JOGO_TIMEOUT_EN.
REQ-011 Port db_estado, output, 4, is the current state code for the debug display.

Function
REQ-012 The controller SHALL be a Moore FSM: every output is a function of the registered state only.
REQ-013 State codes: INICIAL=0000, PREPARA=0001, ESPERA=0010, REGISTRA=0100, COMPARA=0101, PROXIMO=0110, FIM_ACERTO=1010, FIM_ERRO=1110, FIM_TIMEOUT=1101; unused codes SHALL go to INICIAL on the next edge.
REQ-014 INICIAL: all outputs 0; iniciar=1 goes to PREPARA, otherwise the FSM holds.
REQ-015 PREPARA: zeraC=1 and zeraR=1 for exactly one cycle, then unconditionally to ESPERA.
REQ-016 ESPERA: all control outputs 0; jogada_feita=1 goes to REGISTRA, otherwise the FSM holds.
REQ-017 REGISTRA: registraR=1 for exactly one cycle, then to COMPARA; the comparator is therefore valid in COMPARA.
REQ-018 COMPARA transitions:
- igual=0 -> FIM_ERRO
- igual=1 and fimC=1 -> FIM_ACERTO
- igual=1 and fimC=0 -> PROXIMO
REQ-019 PROXIMO: contaC=1 for exactly one cycle, then to ESPERA.
REQ-020 End states: pronto=1; acertou=1 only in FIM_ACERTO, errou=1 only in FIM_ERRO, timeout=1 only in FIM_TIMEOUT; the FSM holds until iniciar=1, which goes to PREPARA.
REQ-021 iniciar SHALL be ignored in every state except INICIAL and the end states.
REQ-022 A jogada_feita pulse arriving outside ESPERA SHALL be ignored and never queued.
REQ-023 At most one of zeraC, contaC, zeraR, registraR SHALL be high in any cycle, except zeraC with zeraR in PREPARA.

Reset
REQ-024 reset=0 SHALL asynchronously force state INICIAL, all outputs to 0, db_estado=0000 and the timeout counter to 0.
REQ-025 Reset asserted mid-round, in any state, SHALL abandon the round; after release the FSM waits in INICIAL for iniciar.

Configuration
REQ-026 Macro JOGO_TIMEOUT_EN defined: a counter clears on every entry to ESPERA and increments each cycle spent in ESPERA.
REQ-027 With JOGO_TIMEOUT_EN defined, when the count reaches TIMEOUT_CYCLES-1 without jogada_feita, the FSM goes to FIM_TIMEOUT.
REQ-028 With JOGO_TIMEOUT_EN defined, jogada_feita in the same cycle as expiry wins and the FSM goes to REGISTRA.
REQ-029 Macro JOGO_TIMEOUT_EN undefined: no counter logic exists, timeout=0, FIM_TIMEOUT is unreachable, and ESPERA waits indefinitely.
REQ-030 The counter width SHALL be $clog2(TIMEOUT_CYCLES).

Structure
REQ-031 The state codes and the default TIMEOUT_CYCLES value SHALL live in shared package jogo_pkg, which is used by db_estado decoding elsewhere.
REQ-032 The timeout counter SHALL be sub-module contador_timeout, with inputs clock, reset, clr and en and output fim; it is instantiated only under JOGO_TIMEOUT_EN.

Verification
REQ-033 Scenario, first reset: reset=0 for 3 cycles then 1 -> db_estado=0000, all outputs 0, and no transition without iniciar.
REQ-034 Scenario, full correct round: with the datapath model, 16 plays all igual=1 and fimC=1 on the 16th -> contaC pulses 15 times, then FIM_ACERTO with acertou=1 and pronto=1.
REQ-035 Scenario, error: the 3rd play has igual=0 -> FIM_ERRO with errou=1 and acertou=0, and exactly 2 contaC pulses.
REQ-036 Scenario, reset mid-operation: reset=0 asserted in REGISTRA -> immediately db_estado=0000 and registraR=0.
REQ-037 Scenario, timeout: with JOGO_TIMEOUT_EN and TIMEOUT_CYCLES=8, no jogada_feita -> FIM_TIMEOUT exactly 8 cycles after entering ESPERA; jogada_feita on cycle 8 -> REGISTRA instead.
REQ-038 Scenario, restart: iniciar=1 in FIM_ERRO -> PREPARA with zeraC=zeraR=1 for one cycle; a jogada_feita pulse in PREPARA is ignored.

Source files
------------

// File: rtl/jogo_pkg.sv
// Shared state codes and defaults for the game controller; db_estado decoders use these codes too.
package jogo_pkg;

    localparam int TIMEOUT_CYCLES_DEF = 5000;

    typedef enum logic [3:0] {
        INICIAL     = 4'b0000,
        PREPARA     = 4'b0001,
        ESPERA      = 4'b0010,
        REGISTRA    = 4'b0100,
        COMPARA     = 4'b0101,
        PROXIMO     = 4'b0110,
        FIM_ACERTO  = 4'b1010,
        FIM_ERRO    = 4'b1110,
        FIM_TIMEOUT = 4'b1101
    } estado_t;

endpackage

// File: rtl/contador_timeout.sv
// Cycle counter for the play-wait window; fim is high on the last allowed cycle.
module contador_timeout #(
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic fim
);
    localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [W-1:0] contagem;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            contagem <= '0;
        else if (clr)
            contagem <= '0;
        else if (en && !fim)
            contagem <= contagem + 1'b1;
    end

    assign fim = (contagem == W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/unidade_controle.sv
// Moore controller for the memory game round. Define JOGO_TIMEOUT_EN to bound the
// wait for each play to TIMEOUT_CYCLES cycles (ends in FIM_TIMEOUT).
module unidade_controle
    import jogo_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada_feita,
    input  logic       igual,
    input  logic       fimC,
    output logic       zeraC,
    output logic       contaC,
    output logic       zeraR,
    output logic       registraR,
    output logic       acertou,
    output logic       errou,
    output logic       pronto,
    output logic       timeout,
    output logic [3:0] db_estado
);
    estado_t estado, proximo;

    if (TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("TIMEOUT_CYCLES must be at least 2");
    end

`ifdef JOGO_TIMEOUT_EN
    logic expirou;

    // Holding clr outside ESPERA makes every entry start from zero.
    contador_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clock (clock),
        .reset (reset),
        .clr   (estado != ESPERA),
        .en    (estado == ESPERA),
        .fim   (expirou)
    );
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            estado <= INICIAL;
        else
            estado <= proximo;
    end

    always_comb begin
        proximo   = INICIAL;
        zeraC     = 1'b0;
        contaC    = 1'b0;
        zeraR     = 1'b0;
        registraR = 1'b0;
        acertou   = 1'b0;
        errou     = 1'b0;
        pronto    = 1'b0;
        timeout   = 1'b0;
        case (estado)
            INICIAL:  proximo = iniciar ? PREPARA : INICIAL;
            PREPARA: begin
                zeraC   = 1'b1;
                zeraR   = 1'b1;
                proximo = ESPERA;
            end
            ESPERA: begin
                proximo = ESPERA;
                // A play arriving on the expiry cycle still counts.
                if (jogada_feita)
                    proximo = REGISTRA;
`ifdef JOGO_TIMEOUT_EN
                else if (expirou)
                    proximo = FIM_TIMEOUT;
`endif
            end
            REGISTRA: begin
                registraR = 1'b1;
                proximo   = COMPARA;
            end
            COMPARA: begin
                if (!igual)
                    proximo = FIM_ERRO;
                else if (fimC)
                    proximo = FIM_ACERTO;
                else
                    proximo = PROXIMO;
            end
            PROXIMO: begin
                contaC  = 1'b1;
                proximo = ESPERA;
            end
            FIM_ACERTO: begin
                acertou = 1'b1;
                pronto  = 1'b1;
                proximo = iniciar ? PREPARA : FIM_ACERTO;
            end
            FIM_ERRO: begin
                errou   = 1'b1;
                pronto  = 1'b1;
                proximo = iniciar ? PREPARA : FIM_ERRO;
            end
            FIM_TIMEOUT: begin
                pronto  = 1'b1;
`ifdef JOGO_TIMEOUT_EN
                timeout = 1'b1;
`endif
                proximo = iniciar ? PREPARA : FIM_TIMEOUT;
            end
            default:  proximo = INICIAL;
        endcase
    end

    assign db_estado = estado;

endmodule

// File: tb/tb_unidade_controle.sv
// Directed bench for unidade_controle with a cycle-level phase model and per-cycle compare.
module tb_unidade_controle;

    localparam int T = 8;
`ifdef JOGO_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic iniciar = 1'b0, jogada_feita = 1'b0, igual = 1'b0, fimC = 1'b0;
    logic zeraC, contaC, zeraR, registraR, acertou, errou, pronto, timeout;
    logic [3:0] db_estado;

    int checks = 0;
    int errors = 0;
    int n_conta = 0;

    unidade_controle #(.TIMEOUT_CYCLES(T)) dut (
        .clock        (clock),
        .reset        (reset),
        .iniciar      (iniciar),
        .jogada_feita (jogada_feita),
        .igual        (igual),
        .fimC         (fimC),
        .zeraC        (zeraC),
        .contaC       (contaC),
        .zeraR        (zeraR),
        .registraR    (registraR),
        .acertou      (acertou),
        .errou        (errou),
        .pronto       (pronto),
        .timeout      (timeout),
        .db_estado    (db_estado)
    );

    always #5 clock = ~clock;

    // Round phases of the game, independent of any encoding
    localparam int P_INI = 0, P_PREP = 1, P_ESP = 2, P_REG = 3, P_CMP = 4,
                   P_PROX = 5, P_OK = 6, P_ERR = 7, P_TO = 8;

    int ph = P_INI;
    int wait_cnt = 0;

    function automatic logic [3:0] code_of(int p);
        case (p)
            P_PREP: return 4'h1;
            P_ESP:  return 4'h2;
            P_REG:  return 4'h4;
            P_CMP:  return 4'h5;
            P_PROX: return 4'h6;
            P_OK:   return 4'hA;
            P_ERR:  return 4'hE;
            P_TO:   return 4'hD;
            default: return 4'h0;
        endcase
    endfunction

    // {zeraC,contaC,zeraR,registraR,acertou,errou,pronto,timeout}
    function automatic logic [7:0] outs_of(int p);
        case (p)
            P_PREP: return 8'b1010_0000;
            P_REG:  return 8'b0001_0000;
            P_PROX: return 8'b0100_0000;
            P_OK:   return 8'b0000_1010;
            P_ERR:  return 8'b0000_0110;
            P_TO:   return 8'b0000_0011;
            default: return 8'b0000_0000;
        endcase
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            ph       <= P_INI;
            wait_cnt <= 0;
        end else begin
            wait_cnt <= (ph == P_ESP) ? wait_cnt + 1 : 0;
            case (ph)
                P_INI, P_OK, P_ERR, P_TO: if (iniciar) ph <= P_PREP;
                P_PREP: ph <= P_ESP;
                P_ESP: begin
                    if (jogada_feita) ph <= P_REG;
                    else if (TO_EN && wait_cnt == T - 1) ph <= P_TO;
                end
                P_REG:  ph <= P_CMP;
                P_CMP:  ph <= !igual ? P_ERR : (fimC ? P_OK : P_PROX);
                P_PROX: ph <= P_ESP;
                default: ph <= P_INI;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    always @(negedge clock) begin
        chk("model_db_estado", {28'd0, db_estado}, {28'd0, code_of(ph)});
        chk("model_outputs",
            {24'd0, zeraC, contaC, zeraR, registraR, acertou, errou, pronto, timeout},
            {24'd0, outs_of(ph)});
        if (contaC) n_conta++;
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // One play from ESPERA; stray drives a jogada_feita pulse in REGISTRA that must be ignored
    task automatic play(input logic ig, input logic fc, input logic stray);
        jogada_feita = 1'b1; igual = ig; fimC = fc;
        tick;
        jogada_feita = stray;
        tick;
        jogada_feita = 1'b0;
        tick;
        if (ig && !fc) tick;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected end before 100000");
        $fatal(1);
    end

    initial begin
        int base;
        #1 reset = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        repeat (4) tick;
        chk("idle_db", {28'd0, db_estado}, 32'h0);
        chk("idle_outs", {24'd0, zeraC, contaC, zeraR, registraR, acertou, errou, pronto, timeout}, 32'h0);

        // Full correct round: 16 plays
        iniciar = 1'b1; tick; iniciar = 1'b0;
        chk("prep_db", {28'd0, db_estado}, 32'h1);
        chk("prep_zera", {30'd0, zeraC, zeraR}, 32'h3);
        tick;
        chk("espera_db", {28'd0, db_estado}, 32'h2);
        base = n_conta;
        for (int i = 0; i < 16; i++) begin
            iniciar = (i % 4 == 1);
            tick;
            iniciar = 1'b0;
            play(1'b1, i == 15, 1'b0);
        end
        chk("acerto_db", {28'd0, db_estado}, 32'hA);
        chk("acerto_flags", {29'd0, acertou, errou, pronto}, 32'b101);
        chk("acerto_contaC", n_conta - base, 15);

        // Error on the 3rd play
        iniciar = 1'b1; tick; iniciar = 1'b0; tick;
        base = n_conta;
        play(1'b1, 1'b0, 1'b0);
        play(1'b1, 1'b0, 1'b1);
        play(1'b0, 1'b0, 1'b0);
        chk("erro_db", {28'd0, db_estado}, 32'hE);
        chk("erro_flags", {29'd0, acertou, errou, pronto}, 32'b011);
        chk("erro_contaC", n_conta - base, 2);

        // Restart from FIM_ERRO with a stray play during PREPARA
        iniciar = 1'b1; tick; iniciar = 1'b0; jogada_feita = 1'b1;
        chk("restart_prep", {26'd0, db_estado, zeraC, zeraR}, {26'd0, 4'h1, 2'b11});
        tick; jogada_feita = 1'b0;
        chk("restart_espera", {28'd0, db_estado}, 32'h2);
        tick;
        chk("restart_no_queue", {28'd0, db_estado}, 32'h2);

        // Reset asserted in REGISTRA
        jogada_feita = 1'b1; igual = 1'b1; fimC = 1'b0;
        tick; jogada_feita = 1'b0;
        chk("registra_on", {27'd0, db_estado, registraR}, {27'd0, 4'h4, 1'b1});
        #2 reset = 1'b0;
        #1;
        chk("reset_async", {27'd0, db_estado, registraR}, 32'h0);
        tick; reset = 1'b1;
        repeat (3) tick;
        chk("reset_holds", {28'd0, db_estado}, 32'h0);

        // Wait window: 8 cycles in ESPERA
        iniciar = 1'b1; tick; iniciar = 1'b0; tick;
        repeat (7) tick;
        chk("wait_cycle8", {28'd0, db_estado}, 32'h2);
        tick;
`ifdef JOGO_TIMEOUT_EN
        chk("timeout_db", {28'd0, db_estado}, 32'hD);
        chk("timeout_flags", {30'd0, timeout, pronto}, 32'b11);
`else
        chk("no_timeout_db", {28'd0, db_estado}, 32'h2);
        chk("no_timeout_flag", {31'd0, timeout}, 32'h0);
`endif

        // Play on the expiry cycle wins
        iniciar = 1'b1; tick; iniciar = 1'b0; tick;
        repeat (7) tick;
        jogada_feita = 1'b1; igual = 1'b1; fimC = 1'b1;
        tick; jogada_feita = 1'b0;
        chk("expiry_play_wins", {28'd0, db_estado}, 32'h4);
        repeat (3) tick;
        chk("final_acerto", {28'd0, db_estado}, 32'hA);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
